// File: rtl/seq_loader.sv
// seq_loader: loads an ASCII nucleotide stream into a sequence RAM write port.
//   Bytes arrive on a valid/ready handshake. A/C/G/T (either case) are folded to
//   upper case and written one cycle after acceptance. Leading CR/LF bytes are
//   dropped, and a later CR/LF ends the sequence. Any other byte raises err.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a new load (ignored while loading)
//   in_data/in_valid     host byte stream
//   in_ready             byte can be accepted this cycle (state == LOAD)
//   din/en_din/we        RAM write data {1'b0, ASCII} and one-cycle strobes
//   addr_din             RAM write address
//   len                  nucleotides written so far (0..N)
//   busy/done/err        LOAD / DONE / ERR state flags
module seq_loader #(
  parameter int unsigned N   = 128,
  parameter int unsigned Bit = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8:0]     din,
  output logic           en_din,
  output logic           we,
  output logic [Bit-1:0] addr_din,
  output logic [Bit:0]   len,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int unsigned CW = Bit + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic [8:0]      r_din;
  logic [Bit-1:0]  r_addr;
  logic            r_wr;

  logic            w_accept;
  logic [7:0]      w_upper;
  logic            w_is_nuc;
  logic            w_is_term;
  logic            w_write;
  logic            w_clear;
  logic [CW-1:0]   w_count_inc;
  logic            w_last;

  // Byte classification; clearing bit 5 folds lower case onto upper case.
  assign w_accept    = in_valid & (r_state == S_LOAD);
  assign w_upper     = in_data & 8'hDF;
  assign w_is_nuc    = (w_upper == 8'h41) | (w_upper == 8'h43) |
                       (w_upper == 8'h47) | (w_upper == 8'h54);
  assign w_is_term   = (in_data == 8'h0A) | (in_data == 8'h0D);
  assign w_write     = w_accept & w_is_nuc;
  assign w_clear     = start & (r_state != S_LOAD);
  assign w_count_inc = r_count + CW'(1);
  assign w_last      = (w_count_inc == CW'(N));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_accept) begin
          if (w_is_nuc) begin
            if (w_last) w_next = S_DONE;
          end else if (w_is_term) begin
            // Terminators before the first nucleotide are blank lines.
            if (r_count != '0) w_next = S_DONE;
          end else begin
            w_next = S_ERR;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Write-port pipeline and length counter; strobe follows the accept by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_din   <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_wr <= w_write;
      if (w_clear) begin
        r_count <= '0;
      end else if (w_write) begin
        r_count <= w_count_inc;
      end
      if (w_write) begin
        r_din  <= {1'b0, w_upper};
        r_addr <= r_count[Bit-1:0];
      end
    end
  end

  assign in_ready = (r_state == S_LOAD);
  assign busy     = (r_state == S_LOAD);
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);
  assign din      = r_din;
  assign en_din   = r_wr;
  assign we       = r_wr;
  assign addr_din = r_addr;
  assign len      = r_count;

endmodule

// File: tb/tb_seq_loader.sv
// Bench for seq_loader: stimulus pushes expected writes into a queue per DUT;
// a negedge monitor pops and compares every write strobe.
module tb_seq_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;

  // DUT A, N=8
  logic       start = 1'b0, in_valid = 1'b0;
  logic       in_ready, en_din, we, busy, done, err;
  logic [8:0] din;
  logic [2:0] addr_din;
  logic [3:0] len;

  // DUT B, N=5
  logic       start5 = 1'b0, in_valid5 = 1'b0;
  logic       in_ready5, en_din5, we5, busy5, done5, err5;
  logic [8:0] din5;
  logic [2:0] addr_din5;
  logic [3:0] len5;

  int total = 0;
  int bad   = 0;

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];

  always #5 clk = ~clk;

  seq_loader #(.N(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .din(din), .en_din(en_din), .we(we), .addr_din(addr_din),
    .len(len), .busy(busy), .done(done), .err(err)
  );

  seq_loader #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .in_data(in_data), .in_valid(in_valid5),
    .in_ready(in_ready5), .din(din5), .en_din(en_din5), .we(we5), .addr_din(addr_din5),
    .len(len5), .busy(busy5), .done(done5), .err(err5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for DUT A.
  always @(negedge clk) begin
    if (!rst && (en_din || we)) begin
      logic [11:0] e;
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL strobe_a: unexpected write addr=%0d din=0x%0h", addr_din, din);
      end else begin
        e = q_a.pop_front();
        if ({en_din, we, addr_din, din} !== {2'b11, e}) begin
          bad++;
          $display("FAIL strobe_a: got en=%b we=%b addr=%0d din=0x%0h expected addr=%0d din=0x%0h",
                   en_din, we, addr_din, din, e[11:9], e[8:0]);
        end
      end
    end
  end

  // Monitor for DUT B.
  always @(negedge clk) begin
    if (!rst && (en_din5 || we5)) begin
      logic [11:0] e;
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL strobe_b: unexpected write addr=%0d din=0x%0h", addr_din5, din5);
      end else begin
        e = q_b.pop_front();
        if ({en_din5, we5, addr_din5, din5} !== {2'b11, e}) begin
          bad++;
          $display("FAIL strobe_b: got en=%b we=%b addr=%0d din=0x%0h expected addr=%0d din=0x%0h",
                   en_din5, we5, addr_din5, din5, e[11:9], e[8:0]);
        end
      end
    end
  end

  // All tasks are entered and left at a falling edge.
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_a_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b);
    int n = 0;
    in_data   = b;
    in_valid5 = 1'b1;
    while (!in_ready5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_b_timeout", 32'(in_ready5), 32'd1);
    @(negedge clk);
    in_valid5 = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_outputs_a", 32'({in_ready, din, en_din, we, addr_din, len, busy, done, err}), 32'd0);
    chk("rst_outputs_b", 32'({in_ready5, din5, en_din5, we5, addr_din5, len5, busy5, done5, err5}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Test 1: "CACTG",LF
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    q_a.push_back({3'd0, 9'h043}); send(8'h43);
    q_a.push_back({3'd1, 9'h041}); send(8'h41);
    q_a.push_back({3'd2, 9'h043}); send(8'h43);
    q_a.push_back({3'd3, 9'h054}); send(8'h54);
    q_a.push_back({3'd4, 9'h047}); send(8'h47);
    send(8'h0A);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_len", 32'(len), 32'd5);
    chk("t1_ready", 32'(in_ready), 32'd0);
    chk("t1_drained", 32'(q_a.size()), 32'd0);

    // Test 6: restart from DONE
    pulse_start();
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_len", 32'(len), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    q_a.push_back({3'd0, 9'h047}); send(8'h47);
    send(8'h0A);
    chk("t6_len1", 32'(len), 32'd1);
    chk("t6_done1", 32'(done), 32'd1);

    // Test 3: "AC",'X' -> error
    pulse_start();
    q_a.push_back({3'd0, 9'h041}); send(8'h41);
    q_a.push_back({3'd1, 9'h043}); send(8'h63);
    send(8'h58);
    repeat (2) @(negedge clk);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_len", 32'(len), 32'd2);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_ready", 32'(in_ready), 32'd0);

    // Test 4: CR,LF,"T",LF
    pulse_start();
    chk("t4_err_clr", 32'(err), 32'd0);
    send(8'h0D);
    send(8'h0A);
    chk("t4_still_load", 32'(busy), 32'd1);
    chk("t4_len0", 32'(len), 32'd0);
    q_a.push_back({3'd0, 9'h054}); send(8'h54);
    send(8'h0A);
    chk("t4_len", 32'(len), 32'd1);
    chk("t4_done", 32'(done), 32'd1);

    // Test 2: N=5, "gattc", no terminator
    pulse_start5: begin
      start5 = 1'b1;
      @(negedge clk);
      start5 = 1'b0;
    end
    q_b.push_back({3'd0, 9'h047}); send5(8'h67);
    q_b.push_back({3'd1, 9'h041}); send5(8'h61);
    q_b.push_back({3'd2, 9'h054}); send5(8'h74);
    q_b.push_back({3'd3, 9'h054}); send5(8'h74);
    q_b.push_back({3'd4, 9'h043}); send5(8'h63);
    chk("t2_done", 32'(done5), 32'd1);
    chk("t2_len", 32'(len5), 32'd5);
    chk("t2_ready", 32'(in_ready5), 32'd0);
    in_data   = 8'h41;
    in_valid5 = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_held", 32'(in_ready5), 32'd0);
    chk("t2_len_hold", 32'(len5), 32'd5);
    in_valid5 = 1'b0;
    chk("t2_drained", 32'(q_b.size()), 32'd0);

    // Test 5: gaps in in_valid, then reset mid-LOAD
    pulse_start();
    q_a.push_back({3'd0, 9'h041}); send(8'h41);
    repeat (2) @(negedge clk);
    chk("t5_gap_len", 32'(len), 32'd1);
    chk("t5_gap_busy", 32'(busy), 32'd1);
    q_a.push_back({3'd1, 9'h043}); send(8'h43);
    chk("t5_len2", 32'(len), 32'd2);
    in_data  = 8'h47;
    in_valid = 1'b1;
    chk("t5_ready_pre", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t5_rst_outputs", 32'({in_ready, din, en_din, we, addr_din, len, busy, done, err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    q_a.push_back({3'd0, 9'h054}); send(8'h54);
    send(8'h0A);
    chk("t5_reload_len", 32'(len), 32'd1);
    chk("t5_reload_done", 32'(done), 32'd1);

    repeat (3) @(negedge clk);
    chk("final_drained_a", 32'(q_a.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
